// File: rtl/kf_pkg.sv
// Shared Kalman-filter datapath definitions: default component width,
// the squared-magnitude FSM state encoding and the abs helper.
package kf_pkg;

  localparam int DW = 16;
  localparam int OW = 2 * DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a two's-complement value; -2^(DW-1) maps to 2^(DW-1), which fits unsigned.
  function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] v);
    return v[DW-1] ? ((~v) + DW'(1)) : v;
  endfunction

endpackage

// File: rtl/sum_sq_mag_if.sv
// Sample-in / result-out handshake bundle for the squared-magnitude stage.
interface sum_sq_mag_if
  import kf_pkg::*;
#(
  parameter int DW = kf_pkg::DW,
  parameter int OW = 2 * DW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic [DW-1:0] y_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] num_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, num_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, num_out
  );

endinterface

// File: rtl/sum_sq_mag_serial_umul.sv
// One-bit-per-cycle shift-add unsigned multiplier step; the caller owns the accumulator.
module serial_umul
  import kf_pkg::*;
#(
  parameter int DW = kf_pkg::DW,
  parameter int OW = 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] mcand,
  input  logic [DW-1:0] mplier,
  input  logic          step,
  input  logic [OW-1:0] acc_in,
  output logic [OW-1:0] acc_out
);

  logic [OW-1:0] mcand_q;
  logic [DW-1:0] mplier_q;
  logic [OW-1:0] addend;

  // Partial product for this step: the shifted multiplicand gated by the current multiplier LSB.
  generate
    for (genvar gi = 0; gi < OW; gi++) begin : g_addend
      assign addend[gi] = mcand_q[gi] & mplier_q[0];
    end
  endgenerate

  assign acc_out = acc_in + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      mcand_q  <= OW'(mcand);
      mplier_q <= mplier;
    end else if (step) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/sum_sq_mag.sv
// Squared magnitude x^2 + y^2 of a signed 2-D sample, using one serial
// multiplier time-shared between the two squares (2*DW cycles per sample).
module sum_sq_mag
  import kf_pkg::*;
#(
  parameter int DW = kf_pkg::DW,
  parameter int OW = 2 * DW
) (
  input logic         clk,
  input logic         rst,
  sum_sq_mag_if.slave bus
);

  localparam int CW = $clog2(DW);

  state_t        state_q;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] acc_d;
  logic [OW-1:0] num_out_q;
  logic          out_valid_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] ay_q;

  logic          last;
  logic          accept;
  logic          mul_load;
  logic          mul_step;
  logic [DW-1:0] mul_op;

  assign last     = (count_q == CW'(DW - 1));
  assign accept   = bus.in_valid && bus.in_ready;
  assign mul_load = ((state_q == IDLE) && accept) || ((state_q == SQ_X) && last);
  assign mul_step = (state_q == SQ_X) || (state_q == SQ_Y);
  // |x| enters straight from the bus on accept; |y| is replayed from its latch after the x pass.
  assign mul_op   = (state_q == IDLE) ? abs_u(bus.x_in) : ay_q;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.num_out   = num_out_q;

  serial_umul #(
    .DW(DW),
    .OW(OW)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .mcand  (mul_op),
    .mplier (mul_op),
    .step   (mul_step),
    .acc_in (acc_q),
    .acc_out(acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      num_out_q   <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      ay_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ay_q    <= abs_u(bus.y_in);
            acc_q   <= '0;
            count_q <= '0;
            state_q <= SQ_X;
          end
        end
        SQ_X: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (last) begin
            count_q <= '0;
            state_q <= SQ_Y;
          end
        end
        SQ_Y: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (last) begin
            num_out_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_sq_mag.sv
// Directed and scoreboarded checks of sum_sq_mag: latency, abs edge cases,
// backpressure, mid-operation reset and a back-to-back random stream.
module tb_sum_sq_mag;
  import kf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sum_sq_mag_if bus ();

  sum_sq_mag dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Present one sample from a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.x_in     = x;
    bus.y_in     = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_low got %b want 0", bus.in_ready);
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.num_out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%b num=%h want valid=0 num=0", bus.out_valid, bus.num_out);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    send(16'd3, 16'd4);
    wait_result(lat);
    vectors++;
    if (lat !== 32) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 32", lat);
    end
    vectors++;
    if (bus.num_out !== 32'h0000_0019) begin
      miscompares++;
      $display("FAIL basic_3_4 got %h want 00000019", bus.num_out);
    end
    consume();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_release got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    $display("test_basic x=3 y=4 latency=%0d num=%h", lat, bus.num_out);
  endtask

  task automatic test_max();
    int lat;
    send(16'h8000, 16'h8000);
    wait_result(lat);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.num_out !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL max_neg got valid=%b num=%h want valid=1 num=80000000", bus.out_valid, bus.num_out);
    end
    $display("test_max x=-32768 y=-32768 num=%h", bus.num_out);
    consume();
  endtask

  task automatic test_mixed_zero();
    int lat;
    send(16'h7FFF, 16'hFFFF);
    wait_result(lat);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.num_out !== 32'h3FFF_0002) begin
      miscompares++;
      $display("FAIL mixed_sign got valid=%b num=%h want valid=1 num=3fff0002", bus.out_valid, bus.num_out);
    end
    $display("test_mixed x=32767 y=-1 num=%h", bus.num_out);
    consume();
    send(16'h0000, 16'h0000);
    wait_result(lat);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.num_out !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_vec got valid=%b num=%h want valid=1 num=0", bus.out_valid, bus.num_out);
    end
    $display("test_zero x=0 y=0 num=%h", bus.num_out);
    consume();
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  bad = 1'b0;
    bit  spurious = 1'b0;
    send(16'd7, 16'hFFF7);
    wait_result(lat);
    bus.x_in = 16'd1;
    bus.y_in = 16'd1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ((i % 2) == 0);
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.num_out !== 32'd130 || bus.in_ready !== 1'b0) begin
        miscompares++;
        bad = 1'b1;
        $display("FAIL backpressure_hold cyc=%0d got valid=%b num=%h ready=%b want valid=1 num=00000082 ready=0",
                 i, bus.out_valid, bus.num_out, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release got ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) spurious = 1'b1;
    end
    vectors++;
    if (spurious !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_ignored_inputs got spurious out_valid=1 want 0");
    end
    $display("test_backpressure x=7 y=-9 num=%h held=%0d", bus.num_out, !bad);
  endtask

  task automatic test_mid_reset();
    int lat;
    bit spurious = 1'b0;
    send(16'd100, 16'd200);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ready_forced got %b want 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.num_out !== 32'd0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_state got valid=%b num=%h ready=%b want valid=0 num=0 ready=1",
               bus.out_valid, bus.num_out, bus.in_ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) spurious = 1'b1;
    end
    vectors++;
    if (spurious !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_result got spurious out_valid=1 want 0");
    end
    send(16'd5, 16'd12);
    wait_result(lat);
    vectors++;
    if (lat !== 32 || bus.num_out !== 32'd169) begin
      miscompares++;
      $display("FAIL midreset_after got lat=%0d num=%h want lat=32 num=000000a9", lat, bus.num_out);
    end
    $display("test_mid_reset then x=5 y=12 num=%h", bus.num_out);
    consume();
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs[50];
    logic [15:0] ys[50];
    logic [31:0] exp_q[$];
    logic [31:0] want;
    longint      sx, sy;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    bit          spurious = 1'b0;
    for (int i = 0; i < 50; i++) begin
      xs[i] = 16'($urandom);
      ys[i] = 16'($urandom);
    end
    xs[0] = 16'h8000;
    ys[0] = 16'h7FFF;
    while (got < 50 && cyc < 20000) begin
      if (sent < 50) begin
        bus.in_valid = 1'b1;
        bus.x_in     = xs[sent];
        bus.y_in     = ys[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) begin
        sx = longint'($signed(xs[sent]));
        sy = longint'($signed(ys[sent]));
        exp_q.push_back(32'(sx * sx + sy * sy));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_unexpected got num=%h want no result", bus.num_out);
        end else begin
          want = exp_q.pop_front();
          if (bus.num_out !== want) begin
            miscompares++;
            $display("FAIL stream_result idx=%0d got %h want %h", got, bus.num_out, want);
          end else begin
            $display("stream idx=%0d num=%h", got, bus.num_out);
          end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (got !== 50 || sent !== 50 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL stream_count got results=%0d sent=%0d pending=%0d want 50/50/0", got, sent, exp_q.size());
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) spurious = 1'b1;
    end
    vectors++;
    if (spurious !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_duplicate got extra out_valid=1 want 0");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_max();
    test_mixed_zero();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
